map_blitter: RTL

- CPU-commanded rectangle engine feeding the map RAM processor port, which the VGA tile renderer scans.
- Fills a rectangle of the 32x32 tile map with one tile index, or copies a rectangle from one map position to another. Used for scrolling, clearing and level drawing without a CPU loop.
- The top level muxes the engine's map port onto the map RAM b-port while busy is high. The CPU polls busy or takes the irq.

---
 rtl/map_blitter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/map_blitter.sv
// rtl/map_blitter.sv - CPU-commanded fill/copy rectangle engine for the 32x32 tile map RAM
module map_blitter (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_cs,
  input  logic        i_read,
  input  logic        i_write,
  input  logic [3:2]  i_address,
  input  logic [31:0] i_data_in,
  output logic [31:0] o_data_out,
  output logic        o_busy,
  output logic        o_irq,
  output logic        o_map_read,
  output logic        o_map_write,
  output logic [11:2] o_map_address,
  output logic [7:0]  o_map_data_out,
  input  logic [7:0]  i_map_data_in
);

  typedef enum logic [1:0] {IDLE, FILL, COPY_RD, COPY_WR} state_t;

  state_t      r_state;
  logic [4:0]  r_dest_row, r_dest_col, r_src_row, r_src_col;
  logic [4:0]  r_w, r_h, r_off_row, r_off_col;
  logic        r_reverse, r_irq_en, r_done;
  logic [7:0]  r_fill;
  logic        r_map_read, r_map_write;
  logic [9:0]  r_map_address;

  logic        w_busy, w_wr_en, w_start, w_rd_ctrl, w_last;
  logic [4:0]  w_init_row, w_init_col, w_next_row, w_next_col;
  logic        w_unused;

  // 5-bit wrapping adds: rectangles wrap around the map edges
  function automatic logic [9:0] map_at(input logic [4:0] br, input logic [4:0] bc,
                                        input logic [4:0] orow, input logic [4:0] ocol);
    return {br + orow, bc + ocol};
  endfunction

  assign w_busy     = (r_state != IDLE);
  assign w_wr_en    = i_cs & i_write & ~w_busy;
  assign w_start    = w_wr_en & (i_address == 2'd3) & i_data_in[0];
  assign w_rd_ctrl  = i_cs & i_read & (i_address == 2'd3);
  assign w_init_row = i_data_in[2] ? r_h : 5'd0;
  assign w_init_col = i_data_in[2] ? r_w : 5'd0;
  assign w_last     = r_reverse ? (r_off_row == 5'd0 && r_off_col == 5'd0)
                                : (r_off_row == r_h && r_off_col == r_w);
  assign w_unused   = ^i_data_in[23:13];

  always_comb begin
    w_next_row = r_off_row;
    w_next_col = r_off_col;
    if (r_reverse) begin
      if (r_off_col == 5'd0) begin
        w_next_col = r_w;
        w_next_row = r_off_row - 5'd1;
      end else begin
        w_next_col = r_off_col - 5'd1;
      end
    end else begin
      if (r_off_col == r_w) begin
        w_next_col = 5'd0;
        w_next_row = r_off_row + 5'd1;
      end else begin
        w_next_col = r_off_col + 5'd1;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_dest_row    <= 5'd0;
      r_dest_col    <= 5'd0;
      r_src_row     <= 5'd0;
      r_src_col     <= 5'd0;
      r_w           <= 5'd0;
      r_h           <= 5'd0;
      r_off_row     <= 5'd0;
      r_off_col     <= 5'd0;
      r_reverse     <= 1'b0;
      r_irq_en      <= 1'b0;
      r_done        <= 1'b0;
      r_fill        <= 8'd0;
      r_map_read    <= 1'b0;
      r_map_write   <= 1'b0;
      r_map_address <= 10'd0;
    end else begin
      if (w_rd_ctrl)
        r_done <= 1'b0;
      if (w_wr_en) begin
        case (i_address)
          2'd0: {r_dest_row, r_dest_col} <= i_data_in[11:2];
          2'd1: {r_src_row, r_src_col}   <= i_data_in[11:2];
          2'd2: begin
            r_w <= i_data_in[4:0];
            r_h <= i_data_in[12:8];
          end
          default: begin
            r_reverse <= i_data_in[2];
            r_irq_en  <= i_data_in[3];
            r_fill    <= i_data_in[31:24];
          end
        endcase
      end
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_done    <= 1'b0;
            r_off_row <= w_init_row;
            r_off_col <= w_init_col;
            if (i_data_in[1]) begin
              r_state       <= COPY_RD;
              r_map_read    <= 1'b1;
              r_map_address <= map_at(r_src_row, r_src_col, w_init_row, w_init_col);
            end else begin
              r_state       <= FILL;
              r_map_write   <= 1'b1;
              r_map_address <= map_at(r_dest_row, r_dest_col, w_init_row, w_init_col);
            end
          end
        end
        FILL: begin
          if (w_last) begin
            r_state     <= IDLE;
            r_map_write <= 1'b0;
            r_done      <= 1'b1;
          end else begin
            r_off_row     <= w_next_row;
            r_off_col     <= w_next_col;
            r_map_address <= map_at(r_dest_row, r_dest_col, w_next_row, w_next_col);
          end
        end
        COPY_RD: begin
          r_state       <= COPY_WR;
          r_map_read    <= 1'b0;
          r_map_write   <= 1'b1;
          r_map_address <= map_at(r_dest_row, r_dest_col, r_off_row, r_off_col);
        end
        COPY_WR: begin
          r_map_write <= 1'b0;
          if (w_last) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end else begin
            r_state       <= COPY_RD;
            r_map_read    <= 1'b1;
            r_off_row     <= w_next_row;
            r_off_col     <= w_next_col;
            r_map_address <= map_at(r_src_row, r_src_col, w_next_row, w_next_col);
          end
        end
      endcase
    end
  end

  always_comb begin
    o_data_out = 32'd0;
    case (i_address)
      2'd0: o_data_out[11:2] = {r_dest_row, r_dest_col};
      2'd1: o_data_out[11:2] = {r_src_row, r_src_col};
      2'd2: begin
        o_data_out[4:0]  = r_w;
        o_data_out[12:8] = r_h;
      end
      default: begin
        o_data_out[0]     = w_busy;
        o_data_out[1]     = r_done;
        o_data_out[2]     = r_reverse;
        o_data_out[3]     = r_irq_en;
        o_data_out[31:24] = r_fill;
      end
    endcase
  end

  // Read data arrives the cycle after the read strobe, i.e. during COPY_WR itself
  assign o_map_data_out = (r_state == COPY_WR) ? i_map_data_in : r_fill;
  assign o_map_read     = r_map_read;
  assign o_map_write    = r_map_write;
  assign o_map_address  = r_map_address;
  assign o_busy         = w_busy;
  assign o_irq          = r_done & r_irq_en;

endmodule
